// File: rtl/uart_tx_sched_if.sv
// Handshake, frame-configuration and line-status bundle between the byte source and uart_tx_sched.
interface uart_tx_sched_if #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
);
  logic [DIV_W-1:0]     div_i;
  logic                 parity_en_i;
  logic                 stop2_i;
  logic [DATA_BITS-1:0] data_i;
  logic                 valid_i;
  logic                 ready_o;
  logic                 tx_o;
  logic                 busy_o;
  logic                 done_o;

  modport master (
    output div_i, parity_en_i, stop2_i, data_i, valid_i,
    input  ready_o, tx_o, busy_o, done_o
  );

  modport slave (
    input  div_i, parity_en_i, stop2_i, data_i, valid_i,
    output ready_o, tx_o, busy_o, done_o
  );
endinterface

// File: rtl/uart_tx_sched.sv
// UART frame scheduler: start, LSB-first data, optional even parity and 1/2 stop bits,
// each slot timed by a per-frame divide-by-D counter latched at accept.
module uart_tx_sched #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input logic            clk,
  input logic            rst_n,
  uart_tx_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [DIV_W-1:0]     bit_cnt;
  logic [DIV_W-1:0]     div_q;
  logic [3:0]           slot_cnt;
  logic [DATA_BITS-1:0] data_sh;
  logic                 par_en_q;
  logic                 par_bit;
  logic                 stop2_q;
  logic                 tx_q;
  logic                 done_q;
  logic                 slot_end;

  assign slot_end    = (bit_cnt == div_q - DIV_W'(1));
  assign bus.ready_o = (state == IDLE);
  assign bus.busy_o  = (state != IDLE);
  assign bus.tx_o    = tx_q;
  assign bus.done_o  = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      slot_cnt <= '0;
      div_q    <= DIV_W'(2);
      data_sh  <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.valid_i) begin
          // Parity is taken from the word at accept because the shifter consumes it.
          data_sh  <= bus.data_i;
          par_bit  <= ^bus.data_i;
          par_en_q <= bus.parity_en_i;
          stop2_q  <= bus.stop2_i;
          div_q    <= (bus.div_i < DIV_W'(2)) ? DIV_W'(2) : bus.div_i;
          bit_cnt  <= '0;
          slot_cnt <= '0;
          tx_q     <= 1'b0;
          state    <= START;
        end
      end else if (!slot_end) begin
        bit_cnt <= bit_cnt + DIV_W'(1);
      end else begin
        bit_cnt <= '0;
        case (state)
          START: begin
            tx_q     <= data_sh[0];
            data_sh  <= data_sh >> 1;
            slot_cnt <= '0;
            state    <= DATA;
          end
          DATA: begin
            if (slot_cnt == 4'(DATA_BITS - 1)) begin
              slot_cnt <= '0;
              if (par_en_q) begin
                tx_q  <= par_bit;
                state <= PARITY;
              end else begin
                tx_q  <= 1'b1;
                state <= STOP;
              end
            end else begin
              tx_q     <= data_sh[0];
              data_sh  <= data_sh >> 1;
              slot_cnt <= slot_cnt + 4'd1;
            end
          end
          PARITY: begin
            tx_q     <= 1'b1;
            slot_cnt <= '0;
            state    <= STOP;
          end
          STOP: begin
            tx_q <= 1'b1;
            if (slot_cnt == {3'b000, stop2_q}) begin
              slot_cnt <= '0;
              done_q   <= 1'b1;
              state    <= IDLE;
            end else begin
              slot_cnt <= slot_cnt + 4'd1;
            end
          end
          default: begin
            tx_q  <= 1'b1;
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Frame scheduler for the UART transmit path. It accepts a data word over a valid/ready handshake and drives the serial line with start, data, optional parity and stop bits. It times every bit with its own divide-by-D bit-period counter, so the baud rate is runtime-configurable per frame. It sits between the host-side byte source and the `tx` pin, replacing the fixed free-running baud toggle with a per-frame sequenced bit clock.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame, sent LSB first (legal range 5..9).
- `DIV_W`, default 16: width of the bit-period divisor.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `div_i`  in  DIV_W  clocks per bit (D); latched at frame accept.
- `parity_en_i`  in  1  1 = append even-parity bit; latched at accept.
- `stop2_i`  in  1  1 = two stop bits, 0 = one; latched at accept.
- `data_i`  in  DATA_BITS  word to send; latched at accept.
- `valid_i`  in  1  source has a word.
- `ready_o`  out  1  block can accept a word (high only in IDLE).
- `tx_o`  out  1  serial line, idle high.
- `busy_o`  out  1  frame in progress (state != IDLE).
- `done_o`  out  1  one-cycle pulse on frame completion.

## Operation
- **Transfer rule:** a transfer occurs on any rising edge where `valid_i` and `ready_o` are both 1. On that edge the block latches `data_i`, `div_i`, `parity_en_i` and `stop2_i`, enters START, and sets `tx_o`=0.
- **States:**
  - IDLE → START (on transfer).
  - START → DATA after D cycles.
  - DATA → PARITY or STOP after DATA_BITS slots.
  - PARITY → STOP after 1 slot.
  - STOP → IDLE after 1 or 2 slots.
- **Slot line values:**
  - START: `tx_o`=0.
  - DATA slot i: `tx_o`=data[i].
  - PARITY: `tx_o`=XOR of all latched data bits, so the total count of 1s is even.
  - STOP: `tx_o`=1.
- **Frame length:** L = 1 + DATA_BITS + parity_en + (stop2 ? 2 : 1) slots.
- **Divisor:** effective D = latched div, but values 0 and 1 are forced to 2. Every slot lasts exactly D cycles.
- **Bit-period counter:** DIV_W bits wide, counts 0..D-1 and wraps to 0 at each slot boundary.
- **Slot counter:** 4 bits, no overflow for L ≤ 13.
- **Input changes mid-frame:** changes on `div_i`, `parity_en_i`, `stop2_i` or `data_i` have no effect until the next transfer.
- **valid_i while busy:** `valid_i` high during a frame is held off by `ready_o`=0. No data is dropped or duplicated.
- **Reset (rst_n=0 on an edge), including mid-frame:**
  - state → IDLE and both counters → 0.
  - `tx_o`=1, `busy_o`=0, `done_o`=0.
  - `ready_o`=1 from the first cycle after the reset edge; handshakes are ignored while `rst_n`=0.
  - An aborted frame produces no `done_o`.

## Timing
- Cycle k is the interval after rising edge k; the transfer edge is edge 0.
- Slot j (j=0 is start) drives `tx_o` during cycles jD .. jD+D-1.
- Latency from transfer to the start bit on the line is 0 cycles after the transfer edge: `tx_o` is registered on that edge.
- At edge L·D:
  - state → IDLE.
  - `done_o`=1 for cycle L·D only.
  - `ready_o`=1 and `busy_o`=0 from cycle L·D.
  - `tx_o` stays 1.
- Back-to-back: with `valid_i` held high, the next transfer is edge L·D+1. Exactly one idle-high cycle separates frames.
- All outputs are registered or decoded directly from state registers. There are no combinational paths from inputs to outputs.

## Test plan
1. **Basic frame.** Reset, then send 0x55 with div=4, no parity, 1 stop. Required: `tx_o` slots 0,1,0,1,0,1,0,1,0,1 at 4 cycles each (40 cycles); `done_o` pulse in cycle 40; `ready_o` high in cycle 40.
2. **Parity and two stop bits.** Send 0x07 with div=3, parity_en=1, stop2=1. Required: L=12; parity slot = 1; stop high during cycles 30..35; `done_o` in cycle 36.
3. **Back-to-back.** Hold `valid_i` high and send 0xA5 then 0x3C with div=2. Required: second start bit begins in cycle 21; exactly one idle-high cycle between frames; two `done_o` pulses.
4. **Divisor clamp and latching.** Send with div_i=1, and also change div_i from 4 to 9 mid-frame. Required: D=2 is used for the clamped frame; D=4 is held for the whole mid-frame-change frame.
5. **Reset mid-frame.** Assert `rst_n`=0 in data slot 3. Required: `tx_o`=1 and `busy_o`=0 after that edge; no `done_o`; the next frame is sent correctly.
6. **Held-off valid while busy.** Pulse `valid_i` with new data while busy. Required: no transfer, and the in-flight frame's bits are unchanged.
